// File: rtl/imager_fsm_responder.sv
// Imager-side FSMIND1/FSMIND0 handshake responder with MSTREAM mask-word capture.
// Optional build macro RESP_TIMEOUT_EN bounds the DONE/RELEASE waits by TIMEOUT cycles.
module imager_fsm_responder #(
   parameter int ACK_DLY  = 1000,
   parameter int DONE_DLY = 2000,
   parameter int CNT_W    = 16,
   parameter int TIMEOUT  = 65535
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             FSMIND1,
   output logic             FSMIND1ACK,
   output logic             FSMIND0,
   input  logic             FSMIND0ACK,
   input  logic             CLKM,
   input  logic             STREAM,
   input  logic [10:1]      MSTREAM,
   output logic [CNT_W-1:0] word_cnt,
   output logic [CNT_W-1:0] last_word_cnt,
   output logic [9:0]       checksum,
   output logic [CNT_W-1:0] subframe_cnt,
   output logic             busy,
   output logic             err
);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_WAIT_ACK  = 3'd1;
   localparam logic [2:0] S_WAIT_DONE = 3'd2;
   localparam logic [2:0] S_DONE      = 3'd3;
   localparam logic [2:0] S_RELEASE   = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] ACK_LAST  = CNT_W'(ACK_DLY - 1);
   localparam logic [CNT_W-1:0] DONE_LAST = CNT_W'(DONE_DLY - 1);

   if (DONE_DLY <= ACK_DLY || ACK_DLY < 1 || TIMEOUT < 1) begin : g_bad_cfg
      $error("imager_fsm_responder: need 1 <= ACK_DLY < DONE_DLY and TIMEOUT >= 1");
   end

   function automatic logic [9:0] xor_fold(input logic [9:0] acc, input logic [9:0] word);
      return acc ^ word;
   endfunction

   logic       f1_meta_r, f1_sync_r, f1_prev_r;
   logic       a0_meta_r, a0_sync_r;
   logic       clkm_meta_r, clkm_sync_r, clkm_prev_r;
   logic       stream_meta_r, stream_sync_r;
   logic [9:0] mstream_r;

   logic [2:0]       state_r, state_nxt_s;
   logic [CNT_W-1:0] dly_cnt_r, dly_nxt_s, sub_nxt_s, word_base_s;
   logic [9:0]       sum_base_s;
   logic             ack_nxt_s, done_nxt_s, start_s, fsm_err_s;
   logic             f1_rise_s, a0_err_s, cap_s, sat_s, to_hit_s;

   // Two-flop synchronizers; MSTREAM gets one stage, it is stable long before CLKM sync completes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         f1_meta_r     <= 1'b0;
         f1_sync_r     <= 1'b0;
         f1_prev_r     <= 1'b0;
         a0_meta_r     <= 1'b0;
         a0_sync_r     <= 1'b0;
         clkm_meta_r   <= 1'b0;
         clkm_sync_r   <= 1'b0;
         clkm_prev_r   <= 1'b0;
         stream_meta_r <= 1'b0;
         stream_sync_r <= 1'b0;
         mstream_r     <= 10'd0;
      end else begin
         f1_meta_r     <= FSMIND1;
         f1_sync_r     <= f1_meta_r;
         f1_prev_r     <= f1_sync_r;
         a0_meta_r     <= FSMIND0ACK;
         a0_sync_r     <= a0_meta_r;
         clkm_meta_r   <= CLKM;
         clkm_sync_r   <= clkm_meta_r;
         clkm_prev_r   <= clkm_sync_r;
         stream_meta_r <= STREAM;
         stream_sync_r <= stream_meta_r;
         mstream_r     <= MSTREAM;
      end
   end

   assign f1_rise_s   = f1_sync_r & ~f1_prev_r;
   assign a0_err_s    = a0_sync_r & (state_r != S_DONE) & (state_r != S_RELEASE);
   assign cap_s       = clkm_sync_r & ~clkm_prev_r & stream_sync_r;
   assign word_base_s = start_s ? {CNT_W{1'b0}} : word_cnt;
   assign sum_base_s  = start_s ? 10'd0 : checksum;
   assign sat_s       = cap_s & (word_base_s == CNT_MAX);

`ifdef RESP_TIMEOUT_EN
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0] to_cnt_r;

   // Release timeout counter, only live while waiting in DONE or RELEASE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == S_DONE || state_r == S_RELEASE) begin
         to_cnt_r <= to_cnt_r + CNT_ONE;
      end else begin
         to_cnt_r <= {CNT_W{1'b0}};
      end
   end

   assign to_hit_s = (state_r == S_DONE || state_r == S_RELEASE) && (to_cnt_r == TO_LAST);
`else
   assign to_hit_s = 1'b0;
`endif

   // Handshake next-state logic
   always_comb begin
      state_nxt_s = state_r;
      dly_nxt_s   = dly_cnt_r;
      ack_nxt_s   = FSMIND1ACK;
      done_nxt_s  = FSMIND0;
      sub_nxt_s   = subframe_cnt;
      start_s     = 1'b0;
      fsm_err_s   = 1'b0;
      case (state_r)
         S_IDLE: begin
            if (f1_rise_s) begin
               state_nxt_s = S_WAIT_ACK;
               dly_nxt_s   = {CNT_W{1'b0}};
               start_s     = 1'b1;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_WAIT_ACK, S_WAIT_DONE: begin
            dly_nxt_s = dly_cnt_r + CNT_ONE;
            if (!f1_sync_r) begin
               fsm_err_s   = 1'b1;
               ack_nxt_s   = 1'b0;
               done_nxt_s  = 1'b0;
               state_nxt_s = S_IDLE;
            end else if (state_r == S_WAIT_ACK && dly_cnt_r == ACK_LAST) begin
               ack_nxt_s   = 1'b1;
               state_nxt_s = S_WAIT_DONE;
            end else if (state_r == S_WAIT_DONE && dly_cnt_r == DONE_LAST) begin
               done_nxt_s  = 1'b1;
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         S_DONE, S_RELEASE: begin
            if (to_hit_s) begin
               fsm_err_s   = 1'b1;
               ack_nxt_s   = 1'b0;
               done_nxt_s  = 1'b0;
               state_nxt_s = S_IDLE;
            end else if (state_r == S_DONE && (a0_sync_r || !f1_sync_r)) begin
               done_nxt_s  = 1'b0;
               sub_nxt_s   = subframe_cnt + CNT_ONE;
               state_nxt_s = S_RELEASE;
            end else if (state_r == S_RELEASE && !f1_sync_r && !a0_sync_r) begin
               ack_nxt_s   = 1'b0;
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = state_r;
            end
         end
         default: begin
            ack_nxt_s   = 1'b0;
            done_nxt_s  = 1'b0;
            state_nxt_s = S_IDLE;
         end
      endcase
   end

   // State, registered handshake outputs and per-subframe word statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r       <= S_IDLE;
         dly_cnt_r     <= {CNT_W{1'b0}};
         FSMIND1ACK    <= 1'b0;
         FSMIND0       <= 1'b0;
         subframe_cnt  <= {CNT_W{1'b0}};
         busy          <= 1'b0;
         err           <= 1'b0;
         last_word_cnt <= {CNT_W{1'b0}};
         word_cnt      <= {CNT_W{1'b0}};
         checksum      <= 10'd0;
      end else begin
         state_r      <= state_nxt_s;
         dly_cnt_r    <= dly_nxt_s;
         FSMIND1ACK   <= ack_nxt_s & f1_sync_r;
         FSMIND0      <= done_nxt_s;
         subframe_cnt <= sub_nxt_s;
         busy         <= (state_nxt_s != S_IDLE);
         err          <= err | fsm_err_s | a0_err_s | sat_s;
         if (start_s) begin
            last_word_cnt <= word_cnt;
         end
         // A word arriving on the request cycle opens the new subframe rather than being lost
         if (cap_s) begin
            word_cnt <= sat_s ? word_base_s : word_base_s + CNT_ONE;
            checksum <= xor_fold(sum_base_s, mstream_r);
         end else begin
            word_cnt <= word_base_s;
            checksum <= sum_base_s;
         end
      end
   end

endmodule

// File: tb/tb_imager_fsm_responder.sv
// Directed self-checking bench for imager_fsm_responder; define RESP_TIMEOUT_EN to add the timeout scenario.
module tb_imager_fsm_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        FSMIND1 = 1'b0;
   logic        FSMIND0ACK = 1'b0;
   logic        CLKM = 1'b0;
   logic        STREAM = 1'b0;
   logic [10:1] MSTREAM = 10'd0;
   logic        FSMIND1ACK, FSMIND0, busy, err;
   logic [15:0] word_cnt, last_word_cnt, subframe_cnt;
   logic [9:0]  checksum;
   int          checks = 0;
   int          failures = 0;

   imager_fsm_responder #(
      .ACK_DLY(1000), .DONE_DLY(2000), .CNT_W(16), .TIMEOUT(100)
   ) dut (
      .clk(clk), .rst(rst), .FSMIND1(FSMIND1), .FSMIND1ACK(FSMIND1ACK),
      .FSMIND0(FSMIND0), .FSMIND0ACK(FSMIND0ACK), .CLKM(CLKM), .STREAM(STREAM),
      .MSTREAM(MSTREAM), .word_cnt(word_cnt), .last_word_cnt(last_word_cnt),
      .checksum(checksum), .subframe_cnt(subframe_cnt), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   // Advance n rising edges, then settle 1 time unit past the edge
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step(3);
      checks++; if (FSMIND0 !== 1'b0 || FSMIND1ACK !== 1'b0) begin failures++; $display("FAIL rst_hold_outs: got %b%b exp 00", FSMIND0, FSMIND1ACK); end
      rst = 1'b0;
      step(2);
      checks++; if (word_cnt !== 16'd0 || last_word_cnt !== 16'd0 || subframe_cnt !== 16'd0) begin failures++; $display("FAIL rst_counts: got %0h %0h %0h exp 0 0 0", word_cnt, last_word_cnt, subframe_cnt); end
      checks++; if (checksum !== 10'd0 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL rst_status: got %0h %b %b exp 0 0 0", checksum, busy, err); end
   endtask

   task automatic test_handshake(input logic [15:0] exp_sub);
      FSMIND1 = 1'b1;
      step(1002);
      checks++; if (FSMIND1ACK !== 1'b0) begin failures++; $display("FAIL ack_early: got %b exp 0", FSMIND1ACK); end
      step(1);
      checks++; if (FSMIND1ACK !== 1'b1 || FSMIND0 !== 1'b0) begin failures++; $display("FAIL ack_at_1003: got ack=%b done=%b exp ack=1 done=0", FSMIND1ACK, FSMIND0); end
      step(999);
      checks++; if (FSMIND0 !== 1'b0) begin failures++; $display("FAIL done_early: got %b exp 0", FSMIND0); end
      step(1);
      checks++; if (FSMIND0 !== 1'b1 || FSMIND1ACK !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL done_at_2003: got done=%b ack=%b busy=%b err=%b exp 1 1 1 0", FSMIND0, FSMIND1ACK, busy, err); end
      FSMIND0ACK = 1'b1;
      step(2);
      checks++; if (FSMIND0 !== 1'b1) begin failures++; $display("FAIL done_hold: got %b exp 1", FSMIND0); end
      step(1);
      checks++; if (FSMIND0 !== 1'b0 || subframe_cnt !== exp_sub || FSMIND1ACK !== 1'b1) begin failures++; $display("FAIL done_ack: got done=%b sub=%0d ack=%b exp 0 %0d 1", FSMIND0, subframe_cnt, FSMIND1ACK, exp_sub); end
      FSMIND1 = 1'b0;
      FSMIND0ACK = 1'b0;
      step(3);
      checks++; if (FSMIND1ACK !== 1'b0 || busy !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL release: got ack=%b busy=%b err=%b exp 0 0 0", FSMIND1ACK, busy, err); end
   endtask

   task automatic test_stream();
      logic [9:0] words [5];
      words[0] = 10'h001; words[1] = 10'h002; words[2] = 10'h004; words[3] = 10'h008; words[4] = 10'h3FF;
      STREAM = 1'b1;
      step(4);
      for (int i = 0; i < 5; i++) begin
         MSTREAM = words[i];
         CLKM = 1'b1;
         step(4);
         CLKM = 1'b0;
         step(4);
      end
      STREAM = 1'b0;
      checks++; if (word_cnt !== 16'd5 || checksum !== 10'h3F0) begin failures++; $display("FAIL stream_capture: got cnt=%0d sum=%0h exp 5 3f0", word_cnt, checksum); end
      // A pulse with STREAM low is ignored
      CLKM = 1'b1; MSTREAM = 10'h155;
      step(4);
      CLKM = 1'b0;
      step(4);
      checks++; if (word_cnt !== 16'd5 || checksum !== 10'h3F0) begin failures++; $display("FAIL stream_gated: got cnt=%0d sum=%0h exp 5 3f0", word_cnt, checksum); end
      FSMIND1 = 1'b1;
      step(3);
      checks++; if (last_word_cnt !== 16'd5 || word_cnt !== 16'd0 || checksum !== 10'd0 || busy !== 1'b1) begin failures++; $display("FAIL stream_latch: got last=%0d cnt=%0d sum=%0h busy=%b exp 5 0 0 1", last_word_cnt, word_cnt, checksum, busy); end
   endtask

   // Continues the request opened by test_stream: state WAIT_ACK, 3 edges after FSMIND1 rose
   task automatic test_abort();
      int ack_seen = 0;
      step(497);
      checks++; if (err !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL abort_pre: got err=%b busy=%b exp 0 1", err, busy); end
      FSMIND1 = 1'b0;
      step(3);
      checks++; if (err !== 1'b1 || busy !== 1'b0 || FSMIND1ACK !== 1'b0) begin failures++; $display("FAIL abort: got err=%b busy=%b ack=%b exp 1 0 0", err, busy, FSMIND1ACK); end
      for (int i = 0; i < 700; i++) begin
         step(1);
         if (FSMIND1ACK !== 1'b0 || FSMIND0 !== 1'b0) ack_seen++;
      end
      checks++; if (ack_seen != 0 || subframe_cnt !== 16'd1) begin failures++; $display("FAIL abort_quiet: got outs_high=%0d sub=%0d exp 0 1", ack_seen, subframe_cnt); end
   endtask

   task automatic test_reset_mid();
      FSMIND1 = 1'b1;
      step(2003);
      checks++; if (FSMIND0 !== 1'b1 || FSMIND1ACK !== 1'b1) begin failures++; $display("FAIL midrst_pre: got done=%b ack=%b exp 1 1", FSMIND0, FSMIND1ACK); end
      #3 rst = 1'b1;
      #1;
      checks++; if (FSMIND0 !== 1'b0 || FSMIND1ACK !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midrst_async: got done=%b ack=%b busy=%b exp 0 0 0", FSMIND0, FSMIND1ACK, busy); end
      checks++; if (err !== 1'b0 || subframe_cnt !== 16'd0 || last_word_cnt !== 16'd0) begin failures++; $display("FAIL midrst_state: got err=%b sub=%0d last=%0d exp 0 0 0", err, subframe_cnt, last_word_cnt); end
      FSMIND1 = 1'b0;
      step(2);
      rst = 1'b0;
      step(2);
      test_handshake(16'd1);
   endtask

`ifdef RESP_TIMEOUT_EN
   task automatic test_timeout();
      FSMIND1 = 1'b1;
      step(2003);
      checks++; if (FSMIND0 !== 1'b1 || err !== 1'b0) begin failures++; $display("FAIL to_pre: got done=%b err=%b exp 1 0", FSMIND0, err); end
      step(99);
      checks++; if (FSMIND0 !== 1'b1 || FSMIND1ACK !== 1'b1) begin failures++; $display("FAIL to_hold: got done=%b ack=%b exp 1 1", FSMIND0, FSMIND1ACK); end
      step(1);
      checks++; if (FSMIND0 !== 1'b0 || FSMIND1ACK !== 1'b0 || err !== 1'b1 || busy !== 1'b0 || subframe_cnt !== 16'd1) begin failures++; $display("FAIL to_fire: got done=%b ack=%b err=%b busy=%b sub=%0d exp 0 0 1 0 1", FSMIND0, FSMIND1ACK, err, busy, subframe_cnt); end
      step(20);
      checks++; if (busy !== 1'b0 || FSMIND1ACK !== 1'b0) begin failures++; $display("FAIL to_no_rearm: got busy=%b ack=%b exp 0 0", busy, FSMIND1ACK); end
      FSMIND1 = 1'b0;
      step(3);
   endtask
`endif

   task automatic test_ack0_err();
      test_reset();
      FSMIND0ACK = 1'b1;
      step(2);
      checks++; if (err !== 1'b0) begin failures++; $display("FAIL ack0_sync: got err=%b exp 0", err); end
      step(1);
      checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL ack0_idle: got err=%b busy=%b exp 1 0", err, busy); end
      FSMIND0ACK = 1'b0;
      step(5);
      checks++; if (err !== 1'b1) begin failures++; $display("FAIL err_sticky: got %b exp 1", err); end
   endtask

   initial begin
      test_reset();
      test_handshake(16'd1);
      test_stream();
      test_abort();
      test_reset_mid();
`ifdef RESP_TIMEOUT_EN
      test_timeout();
`endif
      test_ack0_err();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
